// File: rtl/hazard_ctrl_p.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Tracks E/M/W destinations with Tnew, raises stalls, selects D-stage bypasses, and tracks MDU occupancy.
module hazard_ctrl_p #(
    parameter int REG_AW      = 5,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [TW-1:0]     tuse_rs_d,
    input  logic [TW-1:0]     tuse_rt_d,
    input  logic [REG_AW-1:0] dst_d,
    input  logic [TW-1:0]     tnew_d,
    input  logic              mdu_start_d,
    input  logic              mdu_div_d,
    input  logic              mdu_use_d,
    output logic              stall,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_clr,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic              mdu_busy
);

    localparam logic [CNT_W-1:0]  LP_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0]  LP_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0]  LP_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LP_CNT_ZERO = CNT_W'(0);
    localparam logic [TW-1:0]     LP_T_ZERO   = TW'(0);
    localparam logic [TW-1:0]     LP_T_ONE    = TW'(1);
    localparam logic [REG_AW-1:0] LP_R_ZERO   = REG_AW'(0);

    logic [REG_AW-1:0] r_e_dst;
    logic [TW-1:0]     r_e_tnew;
    logic              r_e_mdu_start;
    logic              r_e_mdu_div;
    logic [REG_AW-1:0] r_m_dst;
    logic [TW-1:0]     r_m_tnew;
    logic [REG_AW-1:0] r_w_dst;
    logic [CNT_W-1:0]  r_busy_cnt;

    logic              w_data_stall;
    logic              w_mdu_busy;
    logic              w_stall;
    logic [1:0]        w_fwd_rs;
    logic [1:0]        w_fwd_rt;

    // An operand hazards against a stage when it will be needed before that stage produces it.
    function automatic logic f_src_stall(
        input logic [REG_AW-1:0] addr,
        input logic [TW-1:0]     tuse,
        input logic [REG_AW-1:0] src_dst,
        input logic [TW-1:0]     src_tnew
    );
        logic hit;
        if ((addr != LP_R_ZERO) && (addr == src_dst) && (tuse < src_tnew)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // The youngest matching stage owns the value; if it is not ready yet, older copies are stale.
    function automatic logic [1:0] f_fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [REG_AW-1:0] e_dst,
        input logic [TW-1:0]     e_tnew,
        input logic [REG_AW-1:0] m_dst,
        input logic [TW-1:0]     m_tnew,
        input logic [REG_AW-1:0] w_dst
    );
        logic [1:0] sel;
        if (addr == LP_R_ZERO) begin
            sel = 2'd0;
        end else if (addr == e_dst) begin
            sel = (e_tnew == LP_T_ZERO) ? 2'd1 : 2'd0;
        end else if (addr == m_dst) begin
            sel = (m_tnew == LP_T_ZERO) ? 2'd2 : 2'd0;
        end else if (addr == w_dst) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Stall and bypass decisions from the D operands against the tracked slots.
    always_comb begin
        w_data_stall = f_src_stall(rs_d, tuse_rs_d, r_e_dst, r_e_tnew)
                     | f_src_stall(rs_d, tuse_rs_d, r_m_dst, r_m_tnew)
                     | f_src_stall(rt_d, tuse_rt_d, r_e_dst, r_e_tnew)
                     | f_src_stall(rt_d, tuse_rt_d, r_m_dst, r_m_tnew);
        w_mdu_busy   = r_e_mdu_start | (r_busy_cnt != LP_CNT_ZERO);
        w_stall      = w_data_stall | (mdu_use_d & w_mdu_busy);
        w_fwd_rs     = f_fwd_sel(rs_d, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
        w_fwd_rt     = f_fwd_sel(rt_d, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew, r_w_dst);
    end

    // Pipeline slot tracking; a stall injects an all-zero bubble into E.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_e_dst       <= LP_R_ZERO;
            r_e_tnew      <= LP_T_ZERO;
            r_e_mdu_start <= 1'b0;
            r_e_mdu_div   <= 1'b0;
            r_m_dst       <= LP_R_ZERO;
            r_m_tnew      <= LP_T_ZERO;
            r_w_dst       <= LP_R_ZERO;
        end else begin
            if (w_stall) begin
                r_e_dst       <= LP_R_ZERO;
                r_e_tnew      <= LP_T_ZERO;
                r_e_mdu_start <= 1'b0;
                r_e_mdu_div   <= 1'b0;
            end else begin
                r_e_dst       <= dst_d;
                r_e_tnew      <= tnew_d;
                r_e_mdu_start <= mdu_start_d;
                r_e_mdu_div   <= mdu_div_d;
            end
            r_m_dst  <= r_e_dst;
            r_m_tnew <= (r_e_tnew == LP_T_ZERO) ? LP_T_ZERO : (r_e_tnew - LP_T_ONE);
            r_w_dst  <= r_m_dst;
        end
    end

    // MDU occupancy counter, loaded as a mult/div leaves E.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy_cnt <= LP_CNT_ZERO;
        end else if (r_e_mdu_start) begin
            r_busy_cnt <= r_e_mdu_div ? LP_DIV_CNT : LP_MULT_CNT;
        end else if (r_busy_cnt != LP_CNT_ZERO) begin
            r_busy_cnt <= r_busy_cnt - LP_CNT_ONE;
        end else begin
            r_busy_cnt <= r_busy_cnt;
        end
    end

    assign stall    = w_stall;
    assign pc_en    = ~w_stall;
    assign fd_en    = ~w_stall;
    assign de_clr   = w_stall;
    assign fwd_rs_d = w_fwd_rs;
    assign fwd_rt_d = w_fwd_rt;
    assign mdu_busy = w_mdu_busy;

endmodule
